muldiv_seq: RTL
===============

Name: muldiv_seq

Overview:
- Multi-cycle HI/LO unit and controller for the 54-instruction CPU.
- Consumes the 6-bit instruction ID from the decoder and sequences iterative signed/unsigned multiply and divide on shared shift-add/subtract hardware.
- Owns the HI/LO registers, serves MFHI/MFLO/MTHI/MTLO, and asserts a stall to the pipeline while an operation is in flight.

Parameters:
- W, 32, operand/HI/LO width; iteration count equals W.
- OP_DIV, 6'd32, instruction ID for DIV.
- OP_DIVU, 6'd33, instruction ID for DIVU.
- OP_MUL, 6'd34, instruction ID for MUL (signed).
- OP_MULTU, 6'd35, instruction ID for MULTU.
- OP_MFHI, 6'd47, instruction ID for MFHI.
- OP_MFLO, 6'd48, instruction ID for MFLO.
- OP_MTHI, 6'd49, instruction ID for MTHI.
- OP_MTLO, 6'd50, instruction ID for MTLO.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  1  current instruction valid in this stage.
- op  in  6  decoder instruction ID.
- rs_data  in  W  operand A / dividend / MTHI/MTLO source.
- rt_data  in  W  operand B / divisor.
- flush  in  1  abort in-flight operation (exception, ERET).
- stall  out  1  pipeline hold.
- busy  out  1  FSM not IDLE.
- done  out  1  one-cycle pulse when HI/LO are updated by mul/div.
- rdata  out  W  HI for MFHI, LO for MFLO, low product for MUL, else 0.
- hi  out  W  HI register.
- lo  out  W  LO register.

Behaviour:
- Reset (async, rst_n=0): state IDLE; hi=0, lo=0, busy=0, done=0, stall=0, counter=0, internal regs=0.
- FSM states: IDLE, MUL_RUN, DIV_RUN, FIX, DONE.
- IDLE: on req with op in {MUL, MULTU}:
  - latch magnitudes (signed only for MUL) and result sign;
  - counter=0; go to MUL_RUN.
- IDLE: on req with op in {DIV, DIVU}: same latch, go to DIV_RUN.
- MUL_RUN: one shift-add step per cycle on the 2W-bit accumulator; after W steps go to FIX.
- DIV_RUN: one restoring-subtract step per cycle; after W steps go to FIX.
- FIX:
  - apply sign correction: product negated if signs differ; quotient negated if signs differ; remainder takes the dividend's sign;
  - write HI/LO; go to DONE.
- DONE: done=1 for this cycle; return to IDLE.
- Accept-to-done latency is W+2 cycles (34 for W=32). Issue at cycle 0; done at cycle 34.
- HI/LO are written on the FIX->DONE edge.
- stall:
  - =1 combinationally while busy and req is asserted with any HI/LO-class op;
  - =1 during the whole operation for the issuing instruction (pipeline holds the mul/div in stage until DONE);
  - =0 in DONE, so the instruction retires.
- MUL writes HI/LO and also drives rdata=low product in DONE.
- MFHI/MFLO in IDLE or DONE: rdata=hi/lo the same cycle, no stall. In DONE, rdata reflects the new values (bypass).
- MTHI/MTLO in IDLE: hi/lo <= rs_data at the next edge; no stall.
- Ops arriving while busy are not accepted; they are held via stall and re-presented by the pipeline.
- Divide by zero: LO=all ones, HI=rs_data (both signed and unsigned); full latency; no exception.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- flush: forces IDLE at the next edge from any state; hi/lo unchanged; done not pulsed. flush in IDLE with req blocks acceptance.
- Non-HI/LO op IDs are ignored.

Optional Feature:
- Macro MULDIV_EARLY_EN.
- With it defined:
  - MUL/MULTU with either operand 0 skip MUL_RUN and go IDLE->FIX, giving HI=LO=0 and done 2 cycles after accept;
  - DIV/DIVU with divisor 0 also go IDLE->FIX, giving the divide-by-zero result 2 cycles after accept.
- Without it: every mul/div takes the full W+2 cycles.

Test Plan:
- MULTU 0xFFFFFFFF*0xFFFFFFFF -> done at cycle 34; HI=0xFFFFFFFE, LO=0x00000001; stall high cycles 0-33.
- MUL -7*3 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB, rdata=0xFFFFFFEB in DONE.
- DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 100/7 -> LO=14, HI=2.
- DIVU 5/0 -> LO=0xFFFFFFFF, HI=5; done at cycle 34, or cycle 2 with MULDIV_EARLY_EN.
- MTHI 0x1234, then MFHI -> rdata=0x1234, no stall. MFLO issued during DIV -> stall until DONE, then rdata=new LO.
- Start DIV, assert flush at cycle 10 -> IDLE next cycle, no done, HI/LO keep prior values. rst_n low mid-MUL -> all outputs 0 immediately.

Source files
------------

// File: rtl/muldiv_seq.sv
// muldiv_seq: multi-cycle HI/LO unit and controller for the 54-instruction CPU.
// Runs iterative signed/unsigned multiply (shift-add) and divide (restoring
// subtract) on one 2W-bit accumulator, owns HI/LO, serves MFHI/MFLO/MTHI/MTLO
// and holds the pipeline while an operation is in flight.
//
// Optional build macro: MULDIV_EARLY_EN -- a multiply with a zero operand or a
// divide by zero skips the iteration phase and finishes 2 cycles after accept.
//
// Ports:
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset
//   req      in   instruction valid in this stage
//   op       in   6-bit decoder instruction ID
//   rs_data  in   operand A / dividend / MTHI-MTLO source
//   rt_data  in   operand B / divisor
//   flush    in   abort any in-flight operation
//   stall    out  pipeline hold
//   busy     out  FSM not idle
//   done     out  one-cycle pulse when mul/div has updated HI/LO
//   rdata    out  HI for MFHI, LO for MFLO, low product for MUL in DONE, else 0
//   hi, lo   out  HI/LO registers
module muldiv_seq #(
  parameter int         W        = 32,
  parameter logic [5:0] OP_DIV   = 6'd32,
  parameter logic [5:0] OP_DIVU  = 6'd33,
  parameter logic [5:0] OP_MUL   = 6'd34,
  parameter logic [5:0] OP_MULTU = 6'd35,
  parameter logic [5:0] OP_MFHI  = 6'd47,
  parameter logic [5:0] OP_MFLO  = 6'd48,
  parameter logic [5:0] OP_MTHI  = 6'd49,
  parameter logic [5:0] OP_MTLO  = 6'd50
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req,
  input  logic [5:0]   op,
  input  logic [W-1:0] rs_data,
  input  logic [W-1:0] rt_data,
  input  logic         flush,
  output logic         stall,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] rdata,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [2:0] {S_IDLE, S_MUL_RUN, S_DIV_RUN, S_FIX, S_DONE} state_t;

  state_t           state, state_n;
  logic [2*W-1:0]   acc;
  logic [W-1:0]     bmag_q;
  logic [CW-1:0]    cnt;
  logic             neg_q, sa_q, dz_q, mulrd_q;

  function automatic logic [W-1:0] cneg(input logic [W-1:0] v, input logic n);
    return n ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [2*W-1:0] cneg2(input logic [2*W-1:0] v, input logic n);
    return n ? (~v + 1'b1) : v;
  endfunction

  // Decode
  logic signed [W-1:0] rs_s, rt_s;
  logic is_mul, is_div, is_signed, is_hilo, accept, early, sa, sb, last;
  logic [W-1:0] a_mag, b_mag;

  assign rs_s      = rs_data;
  assign rt_s      = rt_data;
  assign is_mul    = (op == OP_MUL) || (op == OP_MULTU);
  assign is_div    = (op == OP_DIV) || (op == OP_DIVU);
  assign is_signed = (op == OP_MUL) || (op == OP_DIV);
  assign is_hilo   = is_mul || is_div || (op == OP_MFHI) || (op == OP_MFLO) ||
                     (op == OP_MTHI) || (op == OP_MTLO);
  assign accept    = (state == S_IDLE) && req && !flush && (is_mul || is_div);
  assign sa        = is_signed && (rs_s < 0);
  assign sb        = is_signed && (rt_s < 0);
  assign a_mag     = cneg(rs_data, sa);
  assign b_mag     = cneg(rt_data, sb);
  assign last      = (cnt == CW'(W - 1));

`ifdef MULDIV_EARLY_EN
  assign early = is_mul ? ((rs_data == '0) || (rt_data == '0)) : (rt_data == '0);
`else
  assign early = 1'b0;
`endif

  // Iteration step: multiplier in acc low half shifts out LSB-first while
  // partial products accumulate in the high half; for divide the high half is
  // the partial remainder and quotient bits shift into the low half.
  logic [W:0]     madd, dtrial;
  logic [2*W-1:0] mul_next, div_next;

  assign madd     = {1'b0, acc[2*W-1:W]} + {1'b0, bmag_q};
  assign mul_next = acc[0] ? {madd, acc[W-1:1]} : {1'b0, acc[2*W-1:1]};
  assign dtrial   = acc[2*W-1:W-1] - {1'b0, bmag_q};
  assign div_next = dtrial[W] ? {acc[2*W-2:0], 1'b0}
                              : {dtrial[W-1:0], acc[W-2:0], 1'b1};

  // Sign correction: remainder follows the dividend; divide-by-zero forces
  // LO to all ones (remainder already equals the original dividend).
  logic           is_div_q;
  logic [2*W-1:0] prod;
  logic [W-1:0]   fix_hi, fix_lo;

  assign prod   = cneg2(acc, neg_q);
  assign fix_hi = is_div_q ? cneg(acc[2*W-1:W], sa_q) : prod[2*W-1:W];
  assign fix_lo = is_div_q ? (dz_q ? '1 : cneg(acc[W-1:0], neg_q)) : prod[W-1:0];

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:    if (accept) state_n = early ? S_FIX : (is_mul ? S_MUL_RUN : S_DIV_RUN);
      S_MUL_RUN: if (last) state_n = S_FIX;
      S_DIV_RUN: if (last) state_n = S_FIX;
      S_FIX:     state_n = S_DONE;
      S_DONE:    state_n = S_IDLE;
      default:   state_n = S_IDLE;
    endcase
    if (flush) state_n = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0; bmag_q <= '0; cnt <= '0;
      neg_q <= 1'b0; sa_q <= 1'b0; dz_q <= 1'b0; mulrd_q <= 1'b0; is_div_q <= 1'b0;
      hi <= '0; lo <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            bmag_q   <= b_mag;
            neg_q    <= sa ^ sb;
            sa_q     <= sa;
            dz_q     <= is_div && (rt_data == '0);
            mulrd_q  <= (op == OP_MUL);
            is_div_q <= is_div;
            cnt      <= '0;
            if (early) acc <= is_div ? {a_mag, {W{1'b0}}} : '0;
            else       acc <= {{W{1'b0}}, a_mag};
          end else if (req && !flush) begin
            if (op == OP_MTHI) hi <= rs_data;
            if (op == OP_MTLO) lo <= rs_data;
          end
        end
        S_MUL_RUN: begin acc <= mul_next; cnt <= cnt + 1'b1; end
        S_DIV_RUN: begin acc <= div_next; cnt <= cnt + 1'b1; end
        S_FIX: if (!flush) begin hi <= fix_hi; lo <= fix_lo; end
        default: ;
      endcase
    end
  end

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

  always_comb begin
    stall = 1'b0;
    case (state)
      S_IDLE:                     stall = accept;
      S_MUL_RUN, S_DIV_RUN, S_FIX: stall = req && is_hilo;
      default:                    stall = 1'b0;
    endcase
  end

  // HI/LO are already updated when DONE is entered, so reads here see new values.
  always_comb begin
    rdata = '0;
    if ((state == S_IDLE) || (state == S_DONE)) begin
      if (req && (op == OP_MFHI)) rdata = hi;
      if (req && (op == OP_MFLO)) rdata = lo;
    end
    if ((state == S_DONE) && mulrd_q) rdata = lo;
  end

endmodule
